// File: rtl/enc8b10b_pkg.sv
// Shared definitions for the multi-lane 8b/10b encoder: K-code constants, block
// disparity classes, the RD- lookup tables for the 5b/6b and 3b/4b sub-blocks,
// the A7 x-sets and the per-lane stage-1 record.
package enc8b10b_pkg;

  // How a sub-block reacts to the running disparity in stage 2.
  //   ClsNeutral: sent as-is, RD unchanged.
  //   ClsAlt:     balanced but has a distinct RD+ form (D.7, D.x.3, some K.x.y); RD unchanged.
  //   ClsFlip:    +/-2 disparity; complemented at RD+, flips RD.
  typedef enum logic [1:0] {
    ClsNeutral = 2'd0,
    ClsAlt     = 2'd1,
    ClsFlip    = 2'd2
  } blk_cls_e;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  typedef struct packed {
    logic [5:0] code;  // abcdei, RD- form
    blk_cls_e   cls;
  } blk6_t;

  typedef struct packed {
    logic [3:0] code;  // fghj, RD- form
    blk_cls_e   cls;
  } blk4_t;

  // Stage-1 record: everything about a byte that does not depend on RD.
  typedef struct packed {
    logic [5:0] code6;
    blk_cls_e   cls6;
    logic [3:0] code4;
    blk_cls_e   cls4;
    logic       a7_m;   // swap P7 for A7 when the 4b block starts at RD-
    logic       a7_p;   // swap P7 for A7 when the 4b block starts at RD+
    logic       k_err;
  } s1_lane_t;

  function automatic blk6_t enc_5b6b(input logic [4:0] x);
    blk6_t r;
    r = '{6'b000000, ClsNeutral};
    unique case (x)
      5'd0:  r = '{6'b100111, ClsFlip};
      5'd1:  r = '{6'b011101, ClsFlip};
      5'd2:  r = '{6'b101101, ClsFlip};
      5'd3:  r = '{6'b110001, ClsNeutral};
      5'd4:  r = '{6'b110101, ClsFlip};
      5'd5:  r = '{6'b101001, ClsNeutral};
      5'd6:  r = '{6'b011001, ClsNeutral};
      5'd7:  r = '{6'b111000, ClsAlt};
      5'd8:  r = '{6'b111001, ClsFlip};
      5'd9:  r = '{6'b100101, ClsNeutral};
      5'd10: r = '{6'b010101, ClsNeutral};
      5'd11: r = '{6'b110100, ClsNeutral};
      5'd12: r = '{6'b001101, ClsNeutral};
      5'd13: r = '{6'b101100, ClsNeutral};
      5'd14: r = '{6'b011100, ClsNeutral};
      5'd15: r = '{6'b010111, ClsFlip};
      5'd16: r = '{6'b011011, ClsFlip};
      5'd17: r = '{6'b100011, ClsNeutral};
      5'd18: r = '{6'b010011, ClsNeutral};
      5'd19: r = '{6'b110010, ClsNeutral};
      5'd20: r = '{6'b001011, ClsNeutral};
      5'd21: r = '{6'b101010, ClsNeutral};
      5'd22: r = '{6'b011010, ClsNeutral};
      5'd23: r = '{6'b111010, ClsFlip};
      5'd24: r = '{6'b110011, ClsFlip};
      5'd25: r = '{6'b100110, ClsNeutral};
      5'd26: r = '{6'b010110, ClsNeutral};
      5'd27: r = '{6'b110110, ClsFlip};
      5'd28: r = '{6'b001110, ClsNeutral};
      5'd29: r = '{6'b101110, ClsFlip};
      5'd30: r = '{6'b011110, ClsFlip};
      5'd31: r = '{6'b101011, ClsFlip};
    endcase
    return r;
  endfunction

  // Data 3b/4b; y=7 returns P7, stage 2 swaps in A7 when flagged.
  function automatic blk4_t enc_3b4b(input logic [2:0] y);
    blk4_t r;
    r = '{4'b0000, ClsNeutral};
    unique case (y)
      3'd0: r = '{4'b1011, ClsFlip};
      3'd1: r = '{4'b1001, ClsNeutral};
      3'd2: r = '{4'b0101, ClsNeutral};
      3'd3: r = '{4'b1100, ClsAlt};
      3'd4: r = '{4'b1101, ClsFlip};
      3'd5: r = '{4'b1010, ClsNeutral};
      3'd6: r = '{4'b0110, ClsNeutral};
      3'd7: r = '{4'b1110, ClsFlip};
    endcase
    return r;
  endfunction

  // K28.y 4b codes; every one has a distinct RD+ form.
  function automatic blk4_t enc_k3b4b(input logic [2:0] y);
    blk4_t r;
    r = '{4'b0000, ClsNeutral};
    unique case (y)
      3'd0: r = '{4'b1011, ClsFlip};
      3'd1: r = '{4'b0110, ClsAlt};
      3'd2: r = '{4'b1010, ClsAlt};
      3'd3: r = '{4'b1100, ClsAlt};
      3'd4: r = '{4'b1101, ClsFlip};
      3'd5: r = '{4'b0101, ClsAlt};
      3'd6: r = '{4'b1001, ClsAlt};
      3'd7: r = '{4'b0111, ClsFlip};
    endcase
    return r;
  endfunction

  function automatic logic in_a7_neg_set(input logic [4:0] x);
    return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
  endfunction

  function automatic logic in_a7_pos_set(input logic [4:0] x);
    return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
  endfunction

  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == K23_7) || (b == K27_7) || (b == K29_7) || (b == K30_7);
  endfunction

endpackage

// File: rtl/enc8b10b_lane_s1.sv
// Per-byte, RD-independent 8b/10b lookup (combinational).
// Ports:
//   data_i  byte HGF_EDCBA
//   k_i     control-character flag
//   lane_o  RD- codes, block classes, A7 flags and k_err for this byte
module enc8b10b_lane_s1
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       k_i,
  output s1_lane_t   lane_o
);

  logic [4:0] x;
  logic [2:0] y;
  logic       legal_k;
  blk6_t      b6;
  blk4_t      b4;
  blk4_t      b4k;

  assign x = data_i[4:0];
  assign y = data_i[7:5];

  always_comb begin
    legal_k = k_i && is_legal_k(data_i);
    b6      = enc_5b6b(x);
    b4      = enc_3b4b(y);
    b4k     = enc_k3b4b(y);

    lane_o       = '0;
    lane_o.code6 = b6.code;
    lane_o.cls6  = b6.cls;
    lane_o.code4 = b4.code;
    lane_o.cls4  = b4.cls;
    // An illegal K still goes out as the matching data character.
    lane_o.k_err = k_i && !legal_k;

    if (legal_k && (x == 5'd28)) begin
      lane_o.code6 = 6'b001111;
      lane_o.cls6  = ClsFlip;
      lane_o.code4 = b4k.code;
      lane_o.cls4  = b4k.cls;
    end else if (legal_k) begin
      // K23/27/29/30.7 share the data 6b code but always take A7.
      lane_o.code4 = 4'b0111;
      lane_o.cls4  = ClsFlip;
    end else if (y == 3'd7) begin
      lane_o.a7_m = in_a7_neg_set(x);
      lane_o.a7_p = in_a7_pos_set(x);
    end
  end

endmodule

// File: rtl/enc8b10b_multi.sv
// Multi-lane 8b/10b encoder, two-stage valid/ready pipeline.
// Stage 1 registers the RD-independent lookup of every lane; stage 2 resolves
// running disparity serially lane 0 -> lane N-1 and registers the 10b symbols.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        synchronous clear of pipeline and RD
//   in_valid_i/in_ready_o, in_data_i (8 bits per lane), in_k_i (per lane)
//   out_valid_o/out_ready_i, out_data_o ({a..j} per lane, a = MSB)
//   out_rd_o       RD after the last lane of out_data_o
//   k_err_o        per-lane illegal-K flag aligned with out_data_o
module enc8b10b_multi
  import enc8b10b_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 2,
  parameter bit          RD_INIT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [8*NUM_BYTES-1:0]  in_data_i,
  input  logic [NUM_BYTES-1:0]    in_k_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [10*NUM_BYTES-1:0] out_data_o,
  output logic                    out_rd_o,
  output logic [NUM_BYTES-1:0]    k_err_o
);

  s1_lane_t [NUM_BYTES-1:0] s1_lut;
  s1_lane_t [NUM_BYTES-1:0] s1_q, s1_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     out_valid_q, out_valid_d;
  logic [10*NUM_BYTES-1:0]  out_data_q, out_data_d;
  logic [NUM_BYTES-1:0]     k_err_q, k_err_d;
  // Internal RD and out_rd always hold the same value, so one register serves both.
  logic                     rd_q, rd_d;

  logic                     s2_adv, s1_adv, s1_load, s2_load;
  logic [10*NUM_BYTES-1:0]  enc_d;
  logic [NUM_BYTES-1:0]     kerr_d;
  logic                     rd_chain;
  logic [10:0]              lane_res;

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    enc8b10b_lane_s1 u_lane_s1 (
      .data_i (in_data_i[8*g +: 8]),
      .k_i    (in_k_i[g]),
      .lane_o (s1_lut[g])
    );
  end

  // Returns {rd_out, abcdei, fghj}.
  function automatic logic [10:0] encode_lane(input s1_lane_t l, input logic rd_in);
    logic       rd;
    logic [5:0] c6;
    logic [3:0] c4;
    rd = rd_in;
    c6 = l.code6;
    if (rd && (l.cls6 != ClsNeutral)) c6 = ~c6;
    if (l.cls6 == ClsFlip) rd = ~rd;
    c4 = l.code4;
    if ((rd && l.a7_p) || (!rd && l.a7_m)) c4 = 4'b0111;
    if (rd && (l.cls4 != ClsNeutral)) c4 = ~c4;
    if (l.cls4 == ClsFlip) rd = ~rd;
    return {rd, c6, c4};
  endfunction

  assign s2_adv     = !out_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv && !flush_i;
  assign s1_load    = in_valid_i && in_ready_o;
  assign s2_load    = s2_adv && s1_valid_q && !flush_i;

  always_comb begin
    rd_chain = rd_q;
    enc_d    = '0;
    kerr_d   = '0;
    lane_res = '0;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      lane_res           = encode_lane(s1_q[i], rd_chain);
      enc_d[10*i +: 10]  = lane_res[9:0];
      rd_chain           = lane_res[10];
      kerr_d[i]          = s1_q[i].k_err;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    k_err_d     = k_err_q;
    rd_d        = rd_q;
    if (flush_i) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      k_err_d     = '0;
      rd_d        = RD_INIT;
    end else begin
      if (s1_adv) s1_valid_d = in_valid_i;
      if (s1_load) s1_d = s1_lut;
      if (s2_adv) out_valid_d = s1_valid_q;
      // RD only moves when a word actually enters stage 2.
      if (s2_load) begin
        out_data_d = enc_d;
        k_err_d    = kerr_d;
        rd_d       = rd_chain;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      k_err_q     <= '0;
      rd_q        <= RD_INIT;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      k_err_q     <= k_err_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_rd_o    = rd_q;
  assign k_err_o     = k_err_q;

endmodule
